// File: rtl/keypad_pkg.sv
// Shared types and constants for the vending-machine front-panel keypad scanner.
// Latency: none; this package holds only types, constants and a pure helper function.
// Backpressure: none.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;

  // Classification of one full 4-column scan.
  typedef enum logic [1:0] {
    FRAME_NONE    = 2'd0,
    FRAME_KEY     = 2'd1,
    FRAME_INVALID = 2'd2
  } frame_kind_e;

  // Code is only meaningful for FRAME_KEY and is kept at zero otherwise,
  // so that two frame results can be compared as whole words.
  typedef struct packed {
    frame_kind_e             kind;
    logic [KEY_CODE_W-1:0]   code;
  } frame_t;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  localparam frame_t FRAME_IDLE = '{kind: FRAME_NONE, code: '0};

  // Key code is col*4 + row, i.e. the column index in the upper two bits.
  function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [1:0] col,
                                                        input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Latency: 2 sys_clk cycles from input change to output.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce and one-cycle key strobe.
// Latency: key_valid/key_code/key_held update 1 cycle after the col-3 sample of the debouncing frame.
// Backpressure: none; key_valid is a fire-and-forget strobe, key_code holds until the next acceptance.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,  // dwell cycles per column, at least 4
  parameter int DEBOUNCE_FRAMES = 4      // identical frames before acceptance, at least 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [3:0]            key_row,
  output logic [3:0]            key_col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int                 DWELL_W    = $clog2(SCAN_DIV);
  localparam int                 CNT_W      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]         row_sync;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [1:0]         col_idx;
  logic               sample_pt;
  logic               frame_end;
  logic [3:0]         row_snap [NUM_COLS-1];

  logic [3:0]          col_low [NUM_COLS];
  logic [NUM_COLS-1:0] col_hit;
  logic [NUM_COLS-1:0] col_single;
  logic [1:0]          hit_col;
  logic [1:0]          hit_row;
  frame_t              frame_res;

  frame_t     cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  state_e     state, state_nxt;
  logic       accept;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .async_in (key_row),
    .sync_out (row_sync)
  );

  // Rows need two cycles through the synchronizer, so sampling on the last
  // dwell cycle is what makes SCAN_DIV >= 4 sufficient.
  assign sample_pt = (dwell_cnt == DWELL_LAST);
  assign frame_end = sample_pt && (col_idx == 2'd3);
  assign key_col   = ~(4'b0001 << col_idx);
  assign key_held  = (state == PRESSED);

  // Dwell counter and rotating column index.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
    end else if (sample_pt) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  // Record rows for columns 0..2; column 3 is read live at the frame end.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NUM_COLS - 1; c++) row_snap[c] <= 4'hF;
    end else if (sample_pt) begin
      for (int c = 0; c < NUM_COLS - 1; c++) begin
        if (col_idx == 2'(c)) row_snap[c] <= row_sync;
      end
    end
  end

  // Classify the completed frame as NONE, a single KEY, or INVALID.
  always_comb begin
    for (int c = 0; c < NUM_COLS - 1; c++) col_low[c] = ~row_snap[c];
    col_low[NUM_COLS-1] = ~row_sync;
    col_hit    = '0;
    col_single = '0;
    hit_col    = '0;
    hit_row    = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      col_hit[c]    = |col_low[c];
      col_single[c] = ($countones(col_low[c]) == 1);
      if (col_hit[c]) begin
        hit_col = 2'(c);
        for (int r = 0; r < NUM_ROWS; r++) begin
          if (col_low[c][r]) hit_row = 2'(r);
        end
      end
    end
    frame_res = FRAME_IDLE;
    if (col_hit != '0) begin
      if (($countones(col_hit) == 1) && ((col_hit & col_single) != '0))
        frame_res = '{kind: FRAME_KEY, code: key_code_of(hit_col, hit_row)};
      else
        frame_res = '{kind: FRAME_INVALID, code: '0};
    end
  end

  // Candidate tracking: count repeats of a valid result, restart on change.
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (frame_end) begin
      if ((frame_res == cand) && (frame_res.kind != FRAME_INVALID)) begin
        if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cand_nxt = frame_res;
        cnt_nxt  = (frame_res.kind == FRAME_INVALID) ? '0 : CNT_W'(1);
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cand <= FRAME_IDLE;
      cnt  <= '0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Stable-state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= RELEASED;
    else         state <= state_nxt;
  end

  // Stable-state transitions; only evaluated at a frame end so a saturated
  // count cannot re-trigger. key_code doubles as the stable key.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (frame_end && (cnt_nxt == CNT_MAX)) begin
      case (state)
        RELEASED: begin
          if (cand_nxt.kind == FRAME_KEY) begin
            state_nxt = PRESSED;
            accept    = 1'b1;
          end
        end
        PRESSED: begin
          if (cand_nxt.kind == FRAME_NONE)
            state_nxt = RELEASED;
          else if ((cand_nxt.kind == FRAME_KEY) && (cand_nxt.code != key_code))
            accept = 1'b1;
        end
        default: state_nxt = RELEASED;
      endcase
    end
  end

  // Strobe and held key code.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_nxt.code;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: strobes expected DEBOUNCE_FRAMES frames after the first frame seeing a key.
// Backpressure: none.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int LAT      = DEB * FRAME;  // frame start of first seen frame -> strobe cycle

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit c*4+r = key at column c, row r closed

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb_q[$];
  exp_t got;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index since the last reset edge; cycle 0 is the first one after release.
  always @(posedge sys_clk) cyc <= sys_rst ? 0 : cyc + 1;

  // Passive key matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    key_row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (key_col[c] == 1'b0 && pressed[c*4+r]) key_row[r] = 1'b0;
  end

  // Scoreboard: every strobe must match the oldest expected code and cycle.
  always @(negedge sys_clk) begin
    if (key_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: key_code=%0d at cycle %0d, none required", key_code, cyc);
      end else begin
        got = sb_q.pop_front();
        if (key_code !== got.code || cyc != got.at) begin
          errors++;
          $display("FAIL strobe: key_code=%0d at cycle %0d, required key_code=%0d at cycle %0d",
                   key_code, cyc, got.code, got.at);
        end
      end
    end
  end

  task automatic expect_key(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge sys_clk);
      if (cyc == n) hit = 1'b1;
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL wait_cyc: cycle %0d never reached, now %0d", n, cyc);
    end
  endtask

  // Move to just after the edge that starts a new frame.
  task automatic align_frame(output int s);
    int i = 0;
    do begin
      @(posedge sys_clk);
      #1;
      i++;
    end while ((cyc % FRAME) != 0 && i < 4 * FRAME);
    s = cyc;
  endtask

  task automatic test_reset();
    int         at [5];
    logic [3:0] col [5];
    at  = '{3, 4, 8, 12, 16};
    col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    sys_rst = 1'b1;
    pressed = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wait_cyc(0);
    checks++; if (key_col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", key_col); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held); end
    for (int i = 0; i < 5; i++) begin
      wait_cyc(at[i]);
      checks++;
      if (key_col !== col[i]) begin
        errors++;
        $display("FAIL rotate_col: cycle %0d got %b want %b", at[i], key_col, col[i]);
      end
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL idle_held: got %b want 0", key_held); end
  endtask

  task automatic test_clean_press();
    int s;
    align_frame(s);
    pressed = 16'h0040;  // col 1, row 2 -> code 6
    expect_key(4'd6, s + LAT);
    wait_cyc(s + LAT - 1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_held_early: got %b want 0", key_held); end
    wait_cyc(s + LAT);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL press_code: got %0d want 6", key_code); end
    wait_cyc(s + 5 * FRAME - 1);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held_late: got %b want 1", key_held); end
  endtask

  task automatic test_release();
    int s;
    align_frame(s);
    pressed = '0;
    wait_cyc(s + LAT - 1);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_held_early: got %b want 1", key_held); end
    wait_cyc(s + LAT);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b want 0", key_held); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL release_code: got %0d want 6", key_code); end
  endtask

  task automatic test_bounce();
    int s;
    for (int i = 0; i < 6; i++) begin
      align_frame(s);
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    align_frame(s);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b want 0", key_held); end
    pressed = 16'h0040;
    expect_key(4'd6, s + LAT);
    wait_cyc(s + LAT - 1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_settle_early: got %b want 0", key_held); end
    wait_cyc(s + LAT);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL bounce_settle_held: got %b want 1", key_held); end
  endtask

  task automatic test_invalid();
    int s;
    align_frame(s);
    pressed = '0;
    wait_cyc(s + LAT);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL inv_release: got %b want 0", key_held); end
    align_frame(s);
    pressed = 16'h8001;  // (0,0) and (3,3): keys in two columns
    wait_cyc(s + LAT + FRAME - 1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL inv_two_cols: got %b want 0", key_held); end
    align_frame(s);
    pressed = 16'h0030;  // two rows in column 1
    wait_cyc(s + LAT + FRAME - 1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL inv_two_rows: got %b want 0", key_held); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL inv_code: got %0d want 6", key_code); end
  endtask

  task automatic test_key_change();
    int s;
    align_frame(s);
    pressed = 16'h0020;  // key 5
    expect_key(4'd5, s + LAT);
    wait_cyc(s + LAT);
    checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL change_code5: got %0d want 5", key_code); end
    align_frame(s);
    pressed = 16'h8020;  // key 5 plus key 15: invalid while pressed
    wait_cyc(s + LAT - 1);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL change_inv_held: got %b want 1", key_held); end
    align_frame(s);
    pressed = 16'h0020;  // same stable key again: no new strobe
    wait_cyc(s + LAT);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL change_same_held: got %b want 1", key_held); end
    align_frame(s);
    pressed = 16'h0400;  // key 10
    expect_key(4'd10, s + LAT);
    wait_cyc(s + LAT - 1);
    checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL change_code_early: got %0d want 5", key_code); end
    wait_cyc(s + LAT);
    checks++; if (key_code !== 4'd10) begin errors++; $display("FAIL change_code10: got %0d want 10", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL change_held: got %b want 1", key_held); end
  endtask

  task automatic test_reset_mid();
    int s;
    align_frame(s);
    pressed = 16'h0040;
    expect_key(4'd6, s + LAT);
    wait_cyc(s + LAT + 7);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    expect_key(4'd6, LAT);
    wait_cyc(0);
    checks++; if (key_col !== 4'b1110) begin errors++; $display("FAIL mid_rst_col: got %b want 1110", key_col); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_rst_held: got %b want 0", key_held); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL mid_rst_code: got %0d want 0", key_code); end
    wait_cyc(LAT - 1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_rst_early: got %b want 0", key_held); end
    wait_cyc(LAT);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL mid_rst_held_again: got %b want 1", key_held); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL mid_rst_code_again: got %0d want 6", key_code); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_invalid();
    test_key_change();
    test_reset_mid();
    wait_cyc(LAT + 2 * FRAME);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobe: %0d expected strobes never seen, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
